// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: turns M-stage loads and stores into SRAM-style bus requests,
// generates byte strobes / lane-replicated data and extends load results back into the pipeline.
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memReadM,
  input  logic        memWriteM,
  input  logic [1:0]  mem_opM,
  input  logic        mem_unsignedM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] writeDataM,
  output logic [31:0] readDataM,
  output logic        stall_memM,
  output logic        addr_errM,
  output logic        timeoutM,
  output logic        data_req,
  output logic        data_wr,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  localparam logic [9:0] CntLast = 10'(TIMEOUT - 1);

  state_t      state, nextState;
  logic [9:0]  cnt;
  logic [31:0] rdataQ;
  logic        timeoutQ;

  logic        isByte, isHalf, isWord, access;
  logic        timeoutHit, capture, abort;
  logic [3:0]  storeStrb;
  logic [31:0] storeData, loadValue;
  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  // Reserved size code 11 behaves as a word access.
  assign isByte    = (mem_opM == 2'b00);
  assign isHalf    = (mem_opM == 2'b01);
  assign isWord    = mem_opM[1];
  assign addr_errM = (isHalf & ALUOutM[0]) | (isWord & (ALUOutM[1:0] != 2'b00));
  assign access    = (memReadM | memWriteM) & ~addr_errM;

  assign data_addr  = {ALUOutM[31:2], 2'b00};
  assign data_wr    = memWriteM;
  assign data_wstrb = memWriteM ? storeStrb : 4'b0000;
  assign data_wdata = storeData;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    storeStrb = 4'b1111;
    storeData = writeDataM;
    if (isByte) begin
      storeStrb = 4'b0001 << ALUOutM[1:0];
      storeData = {4{writeDataM[7:0]}};
    end else if (isHalf) begin
      storeStrb = ALUOutM[1] ? 4'b1100 : 4'b0011;
      storeData = {2{writeDataM[15:0]}};
    end
  end

  assign byteSel = data_rdata[{ALUOutM[1:0], 3'b000} +: 8];
  assign halfSel = data_rdata[{ALUOutM[1], 4'b0000} +: 16];

  always_comb begin
    loadValue = data_rdata;
    if (isByte)      loadValue = {{24{~mem_unsignedM & byteSel[7]}}, byteSel};
    else if (isHalf) loadValue = {{16{~mem_unsignedM & halfSel[15]}}, halfSel};
  end

  assign timeoutHit = (cnt == CntLast);

  always_comb begin
    nextState  = state;
    data_req   = 1'b0;
    stall_memM = 1'b0;
    capture    = 1'b0;
    abort      = 1'b0;
    unique case (state)
      S_IDLE: begin
        data_req   = access;
        stall_memM = access;
        if (access) nextState = data_addr_ok ? S_WAIT : S_REQ;
      end
      S_REQ: begin
        data_req   = 1'b1;
        stall_memM = 1'b1;
        if (timeoutHit) begin
          nextState = S_DONE;
          abort     = 1'b1;
        end else if (data_addr_ok) begin
          nextState = S_WAIT;
        end
      end
      S_WAIT: begin
        stall_memM = 1'b1;
        // A response arriving on the last allowed cycle still completes the access.
        if (data_data_ok) begin
          nextState = S_DONE;
          capture   = 1'b1;
        end else if (timeoutHit) begin
          nextState = S_DONE;
          abort     = 1'b1;
        end
      end
      S_DONE: nextState = S_IDLE;
      default: nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      rdataQ   <= '0;
      timeoutQ <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      state <= nextState;
      cnt   <= (state == S_REQ || state == S_WAIT) ? cnt + 10'd1 : 10'd0;
      if (capture)    rdataQ <= memWriteM ? 32'd0 : loadValue;
      else if (abort) rdataQ <= 32'd0;
      if (abort)                 timeoutQ <= 1'b1;
      else if (state == S_DONE)  timeoutQ <= 1'b0;
    end
  end

  assign readDataM = (state == S_DONE) ? rdataQ : 32'd0;
  assign timeoutM  = timeoutQ;

endmodule
